// File: rtl/wb_pkg.sv
// Shared encodings for the write-back stage: result-select codes, load funct3 values
// and the load access width helper.
package wb_pkg;

  typedef enum logic [1:0] {
    WB_SEL_MEM = 2'd0,
    WB_SEL_ALU = 2'd1,
    WB_SEL_PC4 = 2'd2,
    WB_SEL_IMM = 2'd3
  } wb_sel_e;

  localparam logic [2:0] LOAD_LB  = 3'b000;
  localparam logic [2:0] LOAD_LH  = 3'b001;
  localparam logic [2:0] LOAD_LW  = 3'b010;
  localparam logic [2:0] LOAD_LD  = 3'b011;
  localparam logic [2:0] LOAD_LBU = 3'b100;
  localparam logic [2:0] LOAD_LHU = 3'b101;
  localparam logic [2:0] LOAD_LWU = 3'b110;

  // Access width in bytes; 0 marks an encoding that is never a load.
  function automatic logic [3:0] lane_width(input logic [2:0] funct3);
    case (funct3)
      LOAD_LB, LOAD_LBU: lane_width = 4'd1;
      LOAD_LH, LOAD_LHU: lane_width = 4'd2;
      LOAD_LW, LOAD_LWU: lane_width = 4'd4;
      LOAD_LD:           lane_width = 4'd8;
      default:           lane_width = 4'd0;
    endcase
  endfunction

endpackage

// File: rtl/wb_if.sv
// MEM-to-WB bus: pipeline control, instruction fields in, register-file write port and status out.
// master = MEM side / environment, slave = wb_stage.
interface wb_if #(
  parameter int XLEN  = 32,
  parameter int RF_AW = 5,
  parameter int CNT_W = 64
) ();
  logic             stall;
  logic             flush;
  logic             in_valid;
  logic [XLEN-1:0]  in_pc;
  logic [XLEN-1:0]  in_alu;
  logic [XLEN-1:0]  in_mem_rdata;
  logic [XLEN-1:0]  in_imm;
  logic [2:0]       in_funct3;
  logic [1:0]       in_wb_sel;
  logic [RF_AW-1:0] in_rd;
  logic             in_reg_we;

  logic             out_valid;
  logic             rf_we;
  logic [RF_AW-1:0] rf_addr;
  logic [XLEN-1:0]  rf_wdata;
  logic             load_err;
  logic [CNT_W-1:0] retire_count;

  modport master (
    output stall, flush, in_valid, in_pc, in_alu, in_mem_rdata, in_imm,
           in_funct3, in_wb_sel, in_rd, in_reg_we,
    input  out_valid, rf_we, rf_addr, rf_wdata, load_err, retire_count
  );

  modport slave (
    input  stall, flush, in_valid, in_pc, in_alu, in_mem_rdata, in_imm,
           in_funct3, in_wb_sel, in_rd, in_reg_we,
    output out_valid, rf_we, rf_addr, rf_wdata, load_err, retire_count
  );
endinterface

// File: rtl/load_align.sv
// Load data alignment: picks the addressed lane out of the raw dmem word and extends it.
// Purely combinational; err flags illegal encodings and misaligned offsets, with data forced to 0.
module load_align
  import wb_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int OFF_W = (XLEN == 64) ? 3 : 2
) (
  input  logic [XLEN-1:0]  rdata,
  input  logic [OFF_W-1:0] offset,
  input  logic [2:0]       funct3,
  output logic [XLEN-1:0]  data,
  output logic             err
);

  logic [XLEN-1:0] shifted;
  logic [3:0]      lw;

  always_comb begin
    shifted = rdata >> {offset, 3'b000};
    lw      = lane_width(funct3);
    err     = 1'b0;
    data    = '0;
    // LD and LWU only exist on RV64; misalignment is any offset bit below the access width.
    if (lw == 4'd0 || 32'(lw) > (XLEN / 8) || (XLEN == 32 && funct3 == LOAD_LWU)) begin
      err = 1'b1;
    end else if ((offset & OFF_W'(lw - 4'd1)) != '0) begin
      err = 1'b1;
    end else begin
      case (funct3)
        LOAD_LB:  data = XLEN'($signed(shifted[7:0]));
        LOAD_LH:  data = XLEN'($signed(shifted[15:0]));
        LOAD_LW:  data = XLEN'($signed(shifted[31:0]));
        LOAD_LBU: data = XLEN'(shifted[7:0]);
        LOAD_LHU: data = XLEN'(shifted[15:0]);
        LOAD_LWU: data = XLEN'(shifted[31:0]);
        default:  data = shifted;
      endcase
    end
  end

endmodule

// File: rtl/wb_stage.sv
// MEM/WB register with load alignment and result select; drives the register-file write port.
// One-cycle latency; stall holds all outputs, flush inserts a bubble and wins over stall.
module wb_stage
  import wb_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 64,
  parameter int RF_AW = 5
) (
  input logic  clock,
  input logic  reset,
  wb_if.slave  bus
);

  localparam int OFF_W = (XLEN == 64) ? 3 : 2;

  typedef struct packed {
    logic             valid;
    logic             reg_we;
    logic             err;
    logic [RF_AW-1:0] rd;
    logic [XLEN-1:0]  data;
  } wb_reg_t;

  wb_reg_t          wb_d;
  wb_reg_t          wb_q;
  logic [CNT_W-1:0] retire_q;
  logic [XLEN-1:0]  ld_data;
  logic             ld_err;

  load_align #(.XLEN(XLEN), .OFF_W(OFF_W)) u_align (
    .rdata  (bus.in_mem_rdata),
    .offset (bus.in_alu[OFF_W-1:0]),
    .funct3 (bus.in_funct3),
    .data   (ld_data),
    .err    (ld_err)
  );

  always_comb begin
    wb_d        = '0;
    wb_d.valid  = bus.in_valid;
    wb_d.reg_we = bus.in_reg_we;
    wb_d.rd     = bus.in_rd;
    case (wb_sel_e'(bus.in_wb_sel))
      WB_SEL_MEM: begin
        wb_d.data = ld_data;
        // Gated by valid so a bubble never reports an error.
        wb_d.err  = bus.in_valid & ld_err;
      end
      WB_SEL_ALU: wb_d.data = bus.in_alu;
      WB_SEL_PC4: wb_d.data = bus.in_pc + XLEN'(4);
      default:    wb_d.data = bus.in_imm;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wb_q     <= '0;
      retire_q <= '0;
    end else if (bus.flush) begin
      wb_q.valid  <= 1'b0;
      wb_q.reg_we <= 1'b0;
      wb_q.err    <= 1'b0;
    end else if (!bus.stall) begin
      wb_q <= wb_d;
      if (bus.in_valid) retire_q <= retire_q + CNT_W'(1);
    end
  end

  assign bus.out_valid    = wb_q.valid;
  assign bus.rf_we        = wb_q.valid & wb_q.reg_we & (wb_q.rd != '0) & ~wb_q.err;
  assign bus.rf_addr      = wb_q.rd;
  assign bus.rf_wdata     = wb_q.data;
  assign bus.load_err     = wb_q.err;
  assign bus.retire_count = retire_q;

endmodule

// File: tb/tb_wb_stage.sv
// Scoreboard bench for wb_stage (XLEN=32, CNT_W=4): a reference model pushes the expected
// WB state per cycle, which is popped and compared after the clock edge.
module tb_wb_stage;
  localparam int XLEN  = 32;
  localparam int CNT_W = 4;
  localparam int RF_AW = 5;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  wb_if #(.XLEN(XLEN), .RF_AW(RF_AW), .CNT_W(CNT_W)) bus ();

  wb_stage #(.XLEN(XLEN), .CNT_W(CNT_W), .RF_AW(RF_AW)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic             v;
    logic             we;
    logic             err;
    logic             dcare;
    logic [RF_AW-1:0] addr;
    logic [XLEN-1:0]  wdata;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  exp_t model;
  exp_t sb_q[$];
  int   vectors     = 0;
  int   miscompares = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference load: byte-indexed picking, independent of any shifter.
  task automatic ref_load(input logic [31:0] rdata, input logic [31:0] alu, input logic [2:0] f3,
                          output logic [31:0] d, output logic e);
    logic [7:0] b [4];
    int         off;
    for (int i = 0; i < 4; i++) b[i] = rdata[8*i +: 8];
    off = int'(alu[1:0]);
    d   = 32'h0;
    e   = 1'b0;
    case (f3)
      3'd0: d = {{24{b[off][7]}}, b[off]};
      3'd4: d = {24'h0, b[off]};
      3'd1, 3'd5: begin
        if (off % 2 != 0) e = 1'b1;
        else if (f3 == 3'd1) d = {{16{b[off+1][7]}}, b[off+1], b[off]};
        else d = {16'h0, b[off+1], b[off]};
      end
      3'd2: begin
        if (off != 0) e = 1'b1;
        else d = rdata;
      end
      default: e = 1'b1;
    endcase
  endtask

  task automatic apply(input logic rst, input logic stl, input logic fl, input logic v,
                       input logic [1:0] sel, input logic [31:0] pc, input logic [31:0] alu,
                       input logic [31:0] rdata, input logic [31:0] imm, input logic [2:0] f3,
                       input logic [4:0] rd, input logic we);
    logic [31:0] ld;
    logic        le;
    exp_t        e;
    @(negedge clock);
    reset            = rst;
    bus.stall        = stl;
    bus.flush        = fl;
    bus.in_valid     = v;
    bus.in_wb_sel    = sel;
    bus.in_pc        = pc;
    bus.in_alu       = alu;
    bus.in_mem_rdata = rdata;
    bus.in_imm       = imm;
    bus.in_funct3    = f3;
    bus.in_rd        = rd;
    bus.in_reg_we    = we;

    if (rst) begin
      model = '{v: 1'b0, we: 1'b0, err: 1'b0, dcare: 1'b0, addr: '0, wdata: '0, cnt: '0};
    end else if (fl) begin
      model.v     = 1'b0;
      model.we    = 1'b0;
      model.err   = 1'b0;
      model.dcare = 1'b1;
    end else if (!stl) begin
      ref_load(rdata, alu, f3, ld, le);
      model.v     = v;
      model.addr  = rd;
      model.dcare = 1'b0;
      model.err   = 1'b0;
      case (sel)
        2'd0: begin model.wdata = le ? 32'h0 : ld; model.err = v & le; end
        2'd1: model.wdata = alu;
        2'd2: model.wdata = pc + 32'd4;
        default: model.wdata = imm;
      endcase
      model.we = v & we & (rd != 5'd0) & ~model.err;
      if (v) model.cnt = model.cnt + 1'b1;
    end
    sb_q.push_back(model);

    @(posedge clock);
    #1;
    e = sb_q.pop_front();
    check("out_valid", 64'(bus.out_valid), 64'(e.v));
    check("rf_we", 64'(bus.rf_we), 64'(e.we));
    check("load_err", 64'(bus.load_err), 64'(e.err));
    check("retire_count", 64'(bus.retire_count), 64'(e.cnt));
    if (!e.dcare) begin
      check("rf_addr", 64'(bus.rf_addr), 64'(e.addr));
      check("rf_wdata", 64'(bus.rf_wdata), 64'(e.wdata));
    end
  endtask

  localparam logic [31:0] RDW = 32'h80FF_7F01;

  initial begin
    model = '{v: 1'b0, we: 1'b0, err: 1'b0, dcare: 1'b0, addr: '0, wdata: '0, cnt: '0};
    reset = 1'b1;
    bus.stall = 1'b0; bus.flush = 1'b0; bus.in_valid = 1'b0; bus.in_wb_sel = 2'd0;
    bus.in_pc = '0; bus.in_alu = '0; bus.in_mem_rdata = '0; bus.in_imm = '0;
    bus.in_funct3 = 3'd0; bus.in_rd = '0; bus.in_reg_we = 1'b0;

    // Reset state, then a plain ALU write-back.
    apply(1, 0, 0, 0, 2'd0, 0, 0, 0, 0, 3'd0, 5'd0, 0);
    apply(0, 0, 0, 1, 2'd1, 32'h0, 32'h1234_5678, 0, 0, 3'd0, 5'd5, 1);

    // Load lanes: LB at every offset, LHU on the upper half, misaligned LH.
    for (int off = 0; off < 4; off++)
      apply(0, 0, 0, 1, 2'd0, 0, 32'h1000 + 32'(off), RDW, 0, 3'd0, 5'd6, 1);
    apply(0, 0, 0, 1, 2'd0, 0, 32'h1002, RDW, 0, 3'd5, 5'd7, 1);
    apply(0, 0, 0, 1, 2'd0, 0, 32'h1001, RDW, 0, 3'd1, 5'd8, 1);
    apply(0, 0, 0, 1, 2'd0, 0, 32'h1000, RDW, 0, 3'd2, 5'd8, 1);
    apply(0, 0, 0, 1, 2'd0, 0, 32'h1000, RDW, 0, 3'd3, 5'd8, 1);

    // PC+4 wrap, LUI immediate, x0 destination.
    apply(0, 0, 0, 1, 2'd2, 32'hFFFF_FFFC, 0, 0, 0, 3'd0, 5'd9, 1);
    apply(0, 0, 0, 1, 2'd3, 0, 0, 0, 32'hABCD_E000, 3'd0, 5'd10, 1);
    apply(0, 0, 0, 1, 2'd1, 0, 32'hDEAD_BEEF, 0, 0, 3'd0, 5'd0, 1);

    // Capture, then 3 stalled cycles with changing inputs, then stall+flush together.
    apply(0, 0, 0, 1, 2'd1, 0, 32'h0000_CAFE, 0, 0, 3'd0, 5'd11, 1);
    for (int i = 0; i < 3; i++)
      apply(0, 1, 0, 1, 2'd1, 0, 32'h5555_0000 + 32'(i), 0, 0, 3'd0, 5'd12 + 5'(i), 1);
    apply(0, 1, 1, 1, 2'd1, 0, 32'h7777_7777, 0, 0, 3'd0, 5'd13, 1);
    apply(0, 0, 0, 0, 2'd1, 0, 32'h1, 0, 0, 3'd0, 5'd14, 1);

    // 17 captures after reset wrap a 4-bit counter to 1.
    apply(1, 0, 0, 0, 2'd0, 0, 0, 0, 0, 3'd0, 5'd0, 0);
    for (int i = 0; i < 17; i++)
      apply(0, 0, 0, 1, 2'd1, 0, 32'(i), 0, 0, 3'd0, 5'd1 + 5'(i % 31), 1);
    check("wrap_count", 64'(bus.retire_count), 64'd1);

    // Reset in the middle of a stall drops the held instruction.
    apply(0, 0, 0, 1, 2'd1, 0, 32'h0BAD_F00D, 0, 0, 3'd0, 5'd3, 1);
    apply(0, 1, 0, 1, 2'd1, 0, 32'h1111_2222, 0, 0, 3'd0, 5'd4, 1);
    apply(1, 1, 0, 1, 2'd1, 0, 32'h1111_2222, 0, 0, 3'd0, 5'd4, 1);

    // Mixed random traffic.
    for (int i = 0; i < 60; i++)
      apply(0, ($urandom_range(0, 4) == 0), ($urandom_range(0, 9) == 0), 1'($urandom),
            2'($urandom_range(0, 3)), $urandom, $urandom, $urandom, $urandom,
            3'($urandom_range(0, 7)), 5'($urandom_range(0, 31)), 1'($urandom));

    if (sb_q.size() != 0) check("scoreboard_drain", 64'(sb_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- Parametrised write-back stage for the five-stage RISC-V pipeline.
- Combines three functions: the MEM/WB pipeline register, load-data alignment with sign/zero extension, and a four-way result select.
- Drives the register-file write port and a retired-instruction counter.
- Sits between the MEM stage and the register file; its registered outputs also feed the WB→EX/ID forwarding path.

Parameters:
- XLEN, 32, datapath width in bits (32 or 64).
- CNT_W, 64, width of the retired-instruction counter.
- RF_AW, 5, register-file address width.

Ports:
- clock  in  1  pipeline clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- stall  in  1  hold the WB register contents.
- flush  in  1  discard the incoming instruction (insert a bubble).
- in_valid  in  1  MEM stage holds a real instruction.
- in_pc  in  XLEN  PC of the instruction.
- in_alu  in  XLEN  ALU result; also the load address.
- in_mem_rdata  in  XLEN  raw aligned word returned by dmem.
- in_imm  in  XLEN  immediate, used for LUI.
- in_funct3  in  3  load size/sign encoding.
- in_wb_sel  in  2  0=mem, 1=alu, 2=pc+4, 3=imm.
- in_rd  in  RF_AW  destination register.
- in_reg_we  in  1  instruction writes rd.
- out_valid  out  1  WB register holds a valid instruction.
- rf_we  out  1  register-file write enable.
- rf_addr  out  RF_AW  register-file write address.
- rf_wdata  out  XLEN  register-file write data.
- load_err  out  1  illegal load funct3 or misaligned access on the instruction currently in WB.
- retire_count  out  CNT_W  number of instructions retired.

Behaviour:
- Reset: out_valid, rf_we, rf_addr, rf_wdata, load_err and retire_count all read 0 on the cycle after reset is sampled high. Reset overrides every other input.
- Priority at each edge: reset > flush > stall > capture.
- Capture (no reset, no flush, no stall): the register loads result, rd, write enable, in_valid and the error flag. Latency is one cycle from inputs to outputs.
- Flush: out_valid=0 and rf_we=0 on the next cycle, regardless of stall. The data fields may update but must not matter.
- Stall without flush: all outputs hold. rf_we stays asserted if it was already asserted; repeated identical writes are acceptable.
- rf_we = out_valid & registered reg_we & (rf_addr != 0) & !load_err. An x0 write is never issued.
- Result select is computed before the register:
  - sel 0 → aligned load data.
  - sel 1 → in_alu.
  - sel 2 → in_pc + 4, wrapping modulo 2^XLEN.
  - sel 3 → in_imm.
- Load alignment:
  - Byte offset = in_alu[1:0] for XLEN=32, in_alu[2:0] for XLEN=64.
  - Byte lane selected = offset×8; half-word lane selected = offset×8 with offset even.
  - funct3 encodings: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; for XLEN=64 also 011 LD and 110 LWU.
  - Signed loads sign-extend to XLEN; unsigned loads zero-extend.
- load_err is set only when sel=0 and one of the following holds:
  - funct3 is undefined for the current XLEN;
  - LH/LHU with an odd offset;
  - LW/LWU with offset not a multiple of 4;
  - LD with nonzero offset.
  When load_err is set, the aligned data is forced to 0. load_err is registered with the data, and is 0 whenever out_valid is 0.
- retire_count increments by 1 on each edge that performs a capture with in_valid=1. It increments only once per instruction, even across stalls. It wraps from 2^CNT_W−1 to 0, and an instruction with load_err still counts.
- Simultaneous flush and stall: flush wins and no count is taken.
- Reset in the middle of a stall clears everything; the held instruction is lost and not counted.

Decomposition:
- Package wb_pkg holds:
  - WB_SEL_MEM/ALU/PC4/IMM, as a 2-bit typedef;
  - LOAD_* funct3 constants;
  - function lane_width(funct3).
- Sub-module load_align (combinational): inputs rdata, offset, funct3; outputs data, err. It is instantiated once inside wb_stage.

Test Plan:
- Reset, then in_valid=1, sel=1, in_alu=0x1234_5678, rd=5, reg_we=1 → the next cycle gives rf_we=1, rf_addr=5, rf_wdata=0x1234_5678, retire_count=1.
- sel=0, rdata=0x80FF_7F01, LB at offsets 0/1/2/3 → 0x0000_0001, 0x0000_007F, 0xFFFF_FFFF, 0xFFFF_FF80; LHU at offset 2 → 0x0000_80FF.
- LH with in_alu=0x1001 → load_err=1, rf_we=0, rf_wdata=0, retire_count still increments.
- sel=2 with in_pc=0xFFFF_FFFC → rf_wdata=0x0000_0000 (wrap). sel=3 with in_imm=0xABCD_E000 → 0xABCD_E000. rd=0 with reg_we=1 → rf_we=0.
- Capture an instruction, then hold stall=1 for 3 cycles while the inputs change → outputs stay constant and retire_count rises by 1 only. Assert stall and flush together → out_valid=0 next cycle, no count taken.
- Preload near wrap with CNT_W=4: 17 valid captures after reset → retire_count=1. Assert reset during a stall → all outputs 0 on the next cycle.
